mem_req_sequencer: RTL and testbench

- Sits between the pipeline's memory stage and the data memory block, directly upstream of it.
- Converts pipeline load/store requests into the data memory's one-cycle memread/memwrite strobe protocol and tracks that block's clk_stall handshake.
- Stores are posted into a small write FIFO so they do not stall the pipeline.
- Loads wait until the FIFO has drained and all memory activity has finished, then return read data through a response strobe.

---
 rtl/mem_req_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
// Sequences pipeline loads/stores onto the data memory's strobe/clk_stall handshake, posting stores in a FIFO.
// Load strobe in the accept cycle, resp 3 cycles later; store strobe 1 cycle after accept; ready drops on full FIFO or undrained load.
module mem_req_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = 2,
    parameter int STALL_TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_sign_mask,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_memwrite,
    output logic        o_mem_memread,
    output logic [3:0]  o_mem_sign_mask,
    input  logic [31:0] i_mem_read_data,
    input  logic        i_mem_stall,
    output logic        o_busy,
    output logic        o_err_timeout
);

    localparam int TW = $clog2(STALL_TIMEOUT + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mreq_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        WAIT_FALL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    mreq_t              r_fifo [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    mreq_t              r_hold;
    mreq_t              w_req;
    mreq_t              w_cur;
    logic               r_is_load;
    logic [TW-1:0]      r_tmo;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_push;
    logic               w_pop;
    logic               w_load_acc;
    logic               w_rise_tmo;
    logic               w_fall_done;

    assign w_req        = {i_req_addr, i_req_wdata, i_req_sign_mask};
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == (FIFO_AW + 1)'(FIFO_DEPTH));

    // Ready uses the registered count only, so a same-cycle pop never frees a slot.
    assign o_req_ready  = !i_reset && (i_req_write ? !w_fifo_full
                                                   : (w_fifo_empty && r_state == IDLE));
    assign w_push       = i_req_valid && o_req_ready && i_req_write;
    assign w_load_acc   = i_req_valid && o_req_ready && !i_req_write;
    assign w_pop        = !i_reset && (r_state == IDLE) && !w_fifo_empty;
    assign w_rise_tmo   = (r_state == WAIT_RISE) && !i_mem_stall && (r_tmo == TW'(STALL_TIMEOUT - 1));
    assign w_fall_done  = (r_state == WAIT_FALL) && !i_mem_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop || w_load_acc) w_state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (i_mem_stall)     w_state_nxt = WAIT_FALL;
                else if (w_rise_tmo) w_state_nxt = IDLE;
            end
            WAIT_FALL: begin
                if (!i_mem_stall) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cur          = r_hold;
        o_mem_memwrite = 1'b0;
        o_mem_memread  = 1'b0;
        o_resp_valid   = 1'b0;
        o_resp_rdata   = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_cur          = r_fifo[r_rd_ptr];
                    o_mem_memwrite = 1'b1;
                end else if (w_load_acc) begin
                    w_cur          = w_req;
                    o_mem_memread  = 1'b1;
                end
            end
            WAIT_RISE: begin
                // A timed-out load still completes, with zero data.
                if (w_rise_tmo && r_is_load) begin
                    o_resp_valid = 1'b1;
                    o_resp_rdata = '0;
                end
            end
            WAIT_FALL: begin
                if (w_fall_done && r_is_load) begin
                    o_resp_valid = 1'b1;
                    o_resp_rdata = i_mem_read_data;
                end
            end
            default: ;
        endcase
        if (i_reset) begin
            w_cur        = '0;
            o_resp_valid = 1'b0;
            o_resp_rdata = '0;
        end
    end

    assign o_mem_addr       = w_cur.addr;
    assign o_mem_write_data = w_cur.wdata;
    assign o_mem_sign_mask  = w_cur.mask;
    assign o_busy           = !i_reset && (!w_fifo_empty || r_state != IDLE);
    assign o_err_timeout    = r_err;

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_hold    <= '0;
            r_is_load <= 1'b0;
            r_tmo     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            r_count <= r_count + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
            if (w_pop || w_load_acc) begin
                r_hold    <= w_cur;
                r_is_load <= w_load_acc;
                r_tmo     <= '0;
            end else if (r_state == WAIT_RISE) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (o_resp_valid) r_rdata <= o_resp_rdata;
            if (w_rise_tmo)   r_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural data-memory model and event logs.
module tb_mem_req_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sign_mask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = '0;
    logic        mem_stall = 1'b0;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    mem_req_sequencer #(.FIFO_DEPTH(4), .FIFO_AW(2), .STALL_TIMEOUT(8)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_write      (req_write),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .i_req_sign_mask  (req_sign_mask),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_mem_addr       (mem_addr),
        .o_mem_write_data (mem_write_data),
        .o_mem_memwrite   (mem_memwrite),
        .o_mem_memread    (mem_memread),
        .o_mem_sign_mask  (mem_sign_mask),
        .i_mem_read_data  (mem_read_data),
        .i_mem_stall      (mem_stall),
        .o_busy           (busy),
        .o_err_timeout    (err_timeout)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         wlog[$];
    ev_t         rlog[$];
    logic [31:0] mem [logic [31:0]];
    int          rd_cnt   = 0;
    int          cyc      = 0;
    int          scnt     = 0;
    logic        s_strobe = 1'b0;
    logic [31:0] s_addr   = '0;
    logic [31:0] raddr    = '0;
    logic        no_stall = 1'b0;
    int          n_cmp    = 0;
    int          n_mis    = 0;

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h0000_4008) return 32'hDEAD_BEEF;
        return 32'h0;
    endfunction

    // Observe the cycle's strobes mid-cycle; log writes, reads and responses.
    always @(negedge clk) begin
        s_strobe = mem_memwrite || mem_memread;
        s_addr   = mem_addr;
        if (mem_memwrite) begin
            wlog.push_back('{cyc: cyc, a: mem_addr, d: mem_write_data});
            mem[mem_addr] = mem_write_data;
        end
        if (mem_memread) rd_cnt++;
        if (resp_valid) rlog.push_back('{cyc: cyc, a: 32'h0, d: resp_rdata});
    end

    // Memory: stall high for the two cycles after a strobe, data valid when it drops.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_strobe && !no_stall) begin
            mem_stall <= 1'b1;
            scnt      <= 2;
            raddr     <= s_addr;
        end else if (scnt == 2) begin
            scnt <= 1;
        end else if (scnt == 1) begin
            mem_stall     <= 1'b0;
            scnt          <= 0;
            mem_read_data <= rdmem(raddr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic ev_t wget(input int i);
        if (i < wlog.size()) return wlog[i];
        return '{cyc: -1, a: 32'hFFFF_FFFF, d: 32'hFFFF_FFFF};
    endfunction

    function automatic ev_t rget(input int i);
        if (i < rlog.size()) return rlog[i];
        return '{cyc: -1, a: 32'hFFFF_FFFF, d: 32'hFFFF_FFFF};
    endfunction

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        req_valid     = v;
        req_write     = w;
        req_addr      = a;
        req_wdata     = d;
        req_sign_mask = m;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
    endtask

    initial begin
        int   t0, rb, wb, rdb, acc;
        ev_t  ev;

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        #1;
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        tick();
        #1;
        check("idle_load_ready", req_ready, 1);

        // Single load
        rb  = rlog.size();
        rdb = rd_cnt;
        drive(1'b1, 1'b0, 32'h0000_4008, 32'h0, 4'h2);
        #1;
        t0 = cyc;
        check("t1_ready", req_ready, 1);
        check("t1_memread", mem_memread, 1);
        check("t1_mem_addr", mem_addr, 32'h0000_4008);
        check("t1_mask", mem_sign_mask, 32'h2);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            if (rlog.size() > rb) break;
            tick();
        end
        tick();
        tick();
        #1;
        ev = rget(rb);
        check("t1_resp_count", rlog.size() - rb, 1);
        check("t1_resp_cyc", ev.cyc, t0 + 3);
        check("t1_resp_data", ev.d, 32'hDEAD_BEEF);
        check("t1_read_strobes", rd_cnt - rdb, 1);
        check("t1_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        // Back-to-back stores until the FIFO fills
        wait_idle();
        wb = wlog.size();
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 32'h0000_4000 + 32'(4 * k), 32'h100 + 32'(k), 4'hF);
            #1;
            check($sformatf("t2_ready%0d", k), req_ready, 1);
            tick();
        end
        drive(1'b1, 1'b1, 32'h0000_4014, 32'h105, 4'hF);
        #1;
        check("t2_full_ready", req_ready, 0);
        check("t2_pop_strobe", mem_memwrite, 1);
        check("t2_pop_addr", mem_addr, 32'h0000_4004);
        tick();
        #1;
        check("t2_ready_after_pop", req_ready, 1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 40; k++) begin
            if (wlog.size() >= wb + 6) break;
            tick();
        end
        check("t2_write_count", wlog.size() - wb, 6);
        for (int k = 0; k < 6; k++) begin
            ev = wget(wb + k);
            check($sformatf("t2_w%0d_addr", k), ev.a, 32'h0000_4000 + 32'(4 * k));
            check($sformatf("t2_w%0d_data", k), ev.d, 32'h100 + 32'(k));
            check($sformatf("t2_w%0d_cyc", k), ev.cyc, t0 + 1 + 4 * k);
        end

        // Store then load of the same address
        wait_idle();
        rb = rlog.size();
        t0 = cyc;
        drive(1'b1, 1'b1, 32'h0000_4010, 32'h11, 4'hF);
        #1;
        check("t3_store_ready", req_ready, 1);
        tick();
        drive(1'b1, 1'b0, 32'h0000_4010, 32'h0, 4'hF);
        #1;
        check("t3_load_blocked", req_ready, 0);
        acc = -1;
        for (int k = 0; k < 12; k++) begin
            if (req_ready) begin
                acc = cyc;
                break;
            end
            tick();
            #1;
        end
        check("t3_load_accept_cyc", acc, t0 + 5);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            if (rlog.size() > rb) break;
            tick();
        end
        ev = rget(rb);
        check("t3_resp_cyc", ev.cyc, t0 + 8);
        check("t3_resp_data", ev.d, 32'h11);

        // Store to the LED register
        wait_idle();
        drive(1'b1, 1'b1, 32'h0000_2000, 32'h0000_00A5, 4'h3);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("t4_memwrite", mem_memwrite, 1);
        check("t4_addr", mem_addr, 32'h0000_2000);
        check("t4_wdata", mem_write_data, 32'h0000_00A5);
        check("t4_mask", mem_sign_mask, 32'h3);
        tick();
        #1;
        check("t4_strobe_width", mem_memwrite, 0);
        check("t4_addr_hold", mem_addr, 32'h0000_2000);
        tick();
        tick();
        #1;
        check("t4_busy_before", busy, 1);
        tick();
        #1;
        check("t4_busy_fall", busy, 0);

        // Memory never stalls on a load
        wait_idle();
        no_stall = 1'b1;
        rb = rlog.size();
        drive(1'b1, 1'b0, 32'h0000_4008, 32'h0, 4'h2);
        #1;
        t0 = cyc;
        check("t5_memread", mem_memread, 1);
        check("t5_err_before", err_timeout, 0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            if (rlog.size() > rb) break;
            tick();
        end
        #1;
        ev = rget(rb);
        check("t5_resp_cyc", ev.cyc, t0 + 8);
        check("t5_resp_data", ev.d, 32'h0);
        check("t5_err", err_timeout, 1);
        check("t5_idle", busy, 0);
        no_stall = 1'b0;

        // Reset while in WAIT_FALL with three stores queued
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h0000_5000 + 32'(4 * k), 32'h200 + 32'(k), 4'hF);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("t6_busy_pre", busy, 1);
        check("t6_err_sticky", err_timeout, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_busy_post", busy, 0);
        check("t6_err_cleared", err_timeout, 0);
        check("t6_mem_addr", mem_addr, 32'h0);
        wb  = wlog.size();
        rb  = rlog.size();
        rdb = rd_cnt;
        for (int k = 0; k < 12; k++) tick();
        check("t6_no_writes", wlog.size() - wb, 0);
        check("t6_no_reads", rd_cnt - rdb, 0);
        check("t6_no_resp", rlog.size() - rb, 0);
        check("t6_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
